exu_alu_wb: RTL and testbench

ALU writeback stage, directly downstream of the execute-stage ALU. It tracks the destination metadata of each issued ALU operation alongside the ALU's one-cycle internal operand register and captures `alu_result` when it appears. It applies 32-bit sign-extension for word ops and buffers results in a small FIFO toward the register-file write port, which may stall. It raises backpressure to issue so that no ALU result is ever lost.

---
 rtl/exu_pkg.sv | 13 +
 rtl/exu_alu_wb_fifo.sv | 88 ++++++++
 rtl/exu_alu_wb.sv | 135 +++++++++++++
 tb/tb_exu_alu_wb.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exu_pkg.sv
// exu_pkg: types and constants shared by the execute-stage ALU writeback slice.
package exu_pkg;

  localparam int LA64_REG_ADDR_WIDTH = 5;
  localparam int LA64_DATA_WIDTH     = 64;

  // One buffered register-file write.
  typedef struct packed {
    logic [LA64_REG_ADDR_WIDTH-1:0] rd;
    logic [LA64_DATA_WIDTH-1:0]     data;
  } alu_wb_entry_t;

endpackage

// File: rtl/exu_alu_wb_fifo.sv
// exu_alu_wb_fifo: circular buffer of alu_wb_entry_t with occupancy count,
// push/pop and a synchronous clear that takes priority over push/pop.
// Pointers wrap modulo DEPTH, so DEPTH need not be a power of two.
module exu_alu_wb_fifo
  import exu_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr_i,
  input  logic                         push_i,
  input  alu_wb_entry_t                push_entry_i,
  input  logic                         pop_i,
  output alu_wb_entry_t                head_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         empty_o
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  alu_wb_entry_t    mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    if (ptr == PTR_W'(DEPTH - 1)) begin
      return {PTR_W{1'b0}};
    end else begin
      return ptr + PTR_W'(1);
    end
  endfunction

  // Next pointer/count state; clear wins over any push or pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr_i) begin
      wr_ptr_d = {PTR_W{1'b0}};
      rd_ptr_d = {PTR_W{1'b0}};
      count_d  = {CNT_W{1'b0}};
    end else begin
      if (push_i) begin
        wr_ptr_d = next_ptr(wr_ptr_q);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_i) begin
        rd_ptr_d = next_ptr(rd_ptr_q);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are only observed through a non-empty head.
  always_ff @(posedge clk) begin
    if (push_i && !clr_i) begin
      mem_q[wr_ptr_q] <= push_entry_i;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == {CNT_W{1'b0}});

endmodule

// File: rtl/exu_alu_wb.sv
// exu_alu_wb: ALU writeback stage. Tracks destination metadata of each issued
// ALU op in an E1 register alongside the ALU's one-cycle latency, formats the
// result (32-bit sign-extension for word ops) and buffers it toward the
// register-file write port. issue_ready reserves a slot for every op in
// flight, so no result is ever dropped for lack of space.
// Optional feature macro: EXU_ALU_WB_FWD_EN enables the E1 forwarding port;
// when undefined the fwd_* outputs are tied to zero.
module exu_alu_wb
  import exu_pkg::*;
#(
  parameter int DATA_WIDTH     = 64,
  parameter int REG_ADDR_WIDTH = LA64_REG_ADDR_WIDTH,
  parameter int DEPTH          = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      issue_valid,
  output logic                      issue_ready,
  input  logic [REG_ADDR_WIDTH-1:0] issue_rd,
  input  logic                      issue_wen,
  input  logic                      issue_w32,
  input  logic [DATA_WIDTH-1:0]     alu_result,
  input  logic                      flush,
  output logic                      wb_valid,
  input  logic                      wb_ready,
  output logic [REG_ADDR_WIDTH-1:0] wb_rd,
  output logic [DATA_WIDTH-1:0]     wb_data,
  output logic                      fwd_valid,
  output logic [REG_ADDR_WIDTH-1:0] fwd_rd,
  output logic [DATA_WIDTH-1:0]     fwd_data
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                      e1_valid_q, e1_valid_d;
  logic [REG_ADDR_WIDTH-1:0] e1_rd_q, e1_rd_d;
  logic                      e1_wen_q, e1_wen_d;
  logic                      e1_w32_q, e1_w32_d;

  logic                      issue_acc_s;
  logic                      e1_enq_pend_s;
  logic [DATA_WIDTH-1:0]     fmt_s;
  logic [CNT_W:0]            occ_s;
  logic [CNT_W-1:0]          count_s;
  logic                      empty_s;
  logic                      push_s;
  logic                      pop_s;
  alu_wb_entry_t             enq_entry_s;
  alu_wb_entry_t             head_s;

  assign issue_acc_s   = issue_valid & issue_ready & ~flush;
  assign e1_enq_pend_s = e1_valid_q & e1_wen_q & (e1_rd_q != {REG_ADDR_WIDTH{1'b0}});

  // Occupancy including the E1 op that will enqueue at the next edge; built
  // from registered state only so wb_ready never reaches issue_ready.
  assign occ_s       = {1'b0, count_s} + {{CNT_W{1'b0}}, e1_enq_pend_s};
  assign issue_ready = (occ_s < (CNT_W + 1)'(DEPTH));

  // E1 next state: load on an accepted issue, otherwise E1 empties.
  always_comb begin
    e1_valid_d = 1'b0;
    e1_rd_d    = e1_rd_q;
    e1_wen_d   = e1_wen_q;
    e1_w32_d   = e1_w32_q;
    if (issue_acc_s) begin
      e1_valid_d = 1'b1;
      e1_rd_d    = issue_rd;
      e1_wen_d   = issue_wen;
      e1_w32_d   = issue_w32;
    end else begin
      e1_valid_d = 1'b0;
    end
  end

  // E1 metadata register, tracking the ALU's internal operand register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e1_valid_q <= 1'b0;
      e1_rd_q    <= {REG_ADDR_WIDTH{1'b0}};
      e1_wen_q   <= 1'b0;
      e1_w32_q   <= 1'b0;
    end else begin
      e1_valid_q <= e1_valid_d;
      e1_rd_q    <= e1_rd_d;
      e1_wen_q   <= e1_wen_d;
      e1_w32_q   <= e1_w32_d;
    end
  end

  // Result formatting: word ops sign-extend from bit 31.
  always_comb begin
    fmt_s = alu_result;
    if (e1_w32_q) begin
      fmt_s = {{(DATA_WIDTH-32){alu_result[31]}}, alu_result[31:0]};
    end else begin
      fmt_s = alu_result;
    end
  end

  // A flush drops the coincident enqueue; the FIFO clear also wins inside.
  assign push_s         = e1_enq_pend_s & ~flush;
  assign pop_s          = wb_valid & wb_ready;
  assign enq_entry_s.rd   = e1_rd_q;
  assign enq_entry_s.data = fmt_s;

  exu_alu_wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .clr_i        (flush),
    .push_i       (push_s),
    .push_entry_i (enq_entry_s),
    .pop_i        (pop_s),
    .head_o       (head_s),
    .count_o      (count_s),
    .empty_o      (empty_s)
  );

  // Head is gated so that idle write-port fields read as zero.
  assign wb_valid = ~empty_s;
  assign wb_rd    = wb_valid ? head_s.rd   : {REG_ADDR_WIDTH{1'b0}};
  assign wb_data  = wb_valid ? head_s.data : {DATA_WIDTH{1'b0}};

`ifdef EXU_ALU_WB_FWD_EN
  assign fwd_valid = e1_enq_pend_s & ~flush;
  assign fwd_rd    = e1_rd_q;
  assign fwd_data  = e1_valid_q ? fmt_s : {DATA_WIDTH{1'b0}};
`else
  assign fwd_valid = 1'b0;
  assign fwd_rd    = {REG_ADDR_WIDTH{1'b0}};
  assign fwd_data  = {DATA_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_exu_alu_wb.sv
// tb_exu_alu_wb: directed plus randomized bench for exu_alu_wb, checked
// against a queue-based reference model of the writeback stage.
module tb_exu_alu_wb;

  localparam int DEPTH = 3;

  logic        clk;
  logic        rst;
  logic        issue_valid;
  logic        issue_ready;
  logic [4:0]  issue_rd;
  logic        issue_wen;
  logic        issue_w32;
  logic [63:0] alu_result;
  logic        flush;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [63:0] fwd_data;

  int n_vec;
  int n_err;

  typedef struct {
    logic [4:0]  rd;
    logic [63:0] data;
  } wr_t;

  // Reference model: pending op from last cycle plus the queue of writes.
  wr_t        m_q[$];
  bit         m_pend;
  logic [4:0] m_rd;
  bit         m_wen;
  bit         m_w32;

  exu_alu_wb #(
    .DATA_WIDTH     (64),
    .REG_ADDR_WIDTH (5),
    .DEPTH          (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .issue_rd    (issue_rd),
    .issue_wen   (issue_wen),
    .issue_w32   (issue_w32),
    .alu_result  (alu_result),
    .flush       (flush),
    .wb_valid    (wb_valid),
    .wb_ready    (wb_ready),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .fwd_valid   (fwd_valid),
    .fwd_rd      (fwd_rd),
    .fwd_data    (fwd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] fmt(input logic [63:0] r, input bit w32);
    logic signed [31:0] lo;
    longint             ext;
    lo  = r[31:0];
    ext = lo;
    return w32 ? 64'(ext) : r;
  endfunction

  function automatic bit m_live();
    return m_pend && m_wen && (m_rd != 5'd0);
  endfunction

  function automatic bit m_ready();
    return (m_q.size() + (m_live() ? 1 : 0)) < DEPTH;
  endfunction

  function automatic void m_reset();
    m_q.delete();
    m_pend = 1'b0;
    m_rd   = 5'd0;
    m_wen  = 1'b0;
    m_w32  = 1'b0;
  endfunction

  // Drive one cycle's inputs at the falling edge, then compare against model.
  task automatic apply(input bit iv, input logic [4:0] rd, input bit wen, input bit w32,
                       input logic [63:0] alu, input bit fl, input bit wr);
    bit fv;
    @(negedge clk);
    issue_valid = iv;
    issue_rd    = rd;
    issue_wen   = wen;
    issue_w32   = w32;
    alu_result  = alu;
    flush       = fl;
    wb_ready    = wr;
    #1;
    check_val("issue_ready", issue_ready, m_ready());
    check_val("wb_valid", wb_valid, m_q.size() != 0);
    if (m_q.size() != 0) begin
      check_val("wb_rd", wb_rd, m_q[0].rd);
      check_val("wb_data", wb_data, m_q[0].data);
    end else begin
      check_val("wb_rd_idle", wb_rd, 64'd0);
      check_val("wb_data_idle", wb_data, 64'd0);
    end
`ifdef EXU_ALU_WB_FWD_EN
    fv = m_live() && !fl;
    check_val("fwd_valid", fwd_valid, fv);
    if (fv) begin
      check_val("fwd_rd", fwd_rd, m_rd);
      check_val("fwd_data", fwd_data, fmt(alu, m_w32));
    end
`else
    fv = 1'b0;
    check_val("fwd_valid_off", fwd_valid, fv);
    check_val("fwd_rd_off", fwd_rd, 64'd0);
    check_val("fwd_data_off", fwd_data, 64'd0);
`endif
  endtask

  // Advance the model by the rising edge that follows the last apply.
  task automatic tick();
    bit  acc;
    bit  live;
    wr_t e;
    live = m_live();
    acc  = issue_valid && m_ready() && !flush;
    if (m_q.size() != 0 && wb_ready) void'(m_q.pop_front());
    if (live && !flush) begin
      e.rd   = m_rd;
      e.data = fmt(alu_result, m_w32);
      m_q.push_back(e);
    end
    if (flush) m_q.delete();
    m_pend = acc;
    if (acc) begin
      m_rd  = issue_rd;
      m_wen = issue_wen;
      m_w32 = issue_w32;
    end
    @(posedge clk);
  endtask

  task automatic idle(input bit wr);
    apply(1'b0, 5'd0, 1'b0, 1'b0, 64'd0, 1'b0, wr);
    tick();
  endtask

  initial begin
    logic [5:0]  rdy_exp;
    logic [63:0] alu;
    int          sel;

    n_vec = 0;
    n_err = 0;
    m_reset();
    rst = 1'b1;
    issue_valid = 1'b0; issue_rd = 5'd0; issue_wen = 1'b0; issue_w32 = 1'b0;
    alu_result = 64'hDEAD_BEEF_DEAD_BEEF; flush = 1'b0; wb_ready = 1'b0;

    // Reset values.
    @(negedge clk);
    #1;
    check_val("rst_wb_valid", wb_valid, 64'd0);
    check_val("rst_wb_rd", wb_rd, 64'd0);
    check_val("rst_wb_data", wb_data, 64'd0);
    check_val("rst_fwd_valid", fwd_valid, 64'd0);
    check_val("rst_fwd_rd", fwd_rd, 64'd0);
    check_val("rst_fwd_data", fwd_data, 64'd0);
    check_val("rst_issue_ready", issue_ready, 64'd1);
    rst = 1'b0;

    // Plain 64-bit op: visible at t+2 for exactly one cycle.
    apply(1'b1, 5'd5, 1'b1, 1'b0, 64'd0, 1'b0, 1'b1); tick();
    apply(1'b0, 5'd0, 1'b0, 1'b0, 64'h1234_5678_9ABC_DEF0, 1'b0, 1'b1); tick();
    apply(1'b0, 5'd0, 1'b0, 1'b0, 64'd0, 1'b0, 1'b1);
    check_val("t2_wb_valid", wb_valid, 64'd1);
    check_val("t2_wb_rd", wb_rd, 64'd5);
    check_val("t2_wb_data", wb_data, 64'h1234_5678_9ABC_DEF0);
    tick();
    apply(1'b0, 5'd0, 1'b0, 1'b0, 64'd0, 1'b0, 1'b1);
    check_val("t3_wb_valid", wb_valid, 64'd0);
    tick();

    // Word ops, forwarding on rd=7.
    apply(1'b1, 5'd7, 1'b1, 1'b1, 64'd0, 1'b0, 1'b1); tick();
    apply(1'b1, 5'd9, 1'b1, 1'b1, 64'h0000_0000_8000_0001, 1'b0, 1'b1);
`ifdef EXU_ALU_WB_FWD_EN
    check_val("fwd7_valid", fwd_valid, 64'd1);
    check_val("fwd7_rd", fwd_rd, 64'd7);
    check_val("fwd7_data", fwd_data, 64'hFFFF_FFFF_8000_0001);
`else
    check_val("fwd7_off", fwd_valid, 64'd0);
`endif
    tick();
    apply(1'b0, 5'd0, 1'b0, 1'b0, 64'hFFFF_FFFF_7FFF_FFFF, 1'b0, 1'b1);
    check_val("w32_neg", wb_data, 64'hFFFF_FFFF_8000_0001);
    tick();
    apply(1'b0, 5'd0, 1'b0, 1'b0, 64'd0, 1'b0, 1'b1);
    check_val("w32_pos", wb_data, 64'h0000_0000_7FFF_FFFF);
    tick();
    idle(1'b1);

    // Six back-to-back issues with the write port stalled.
    rdy_exp = 6'b000111;
    for (int i = 0; i < 6; i++) begin
      apply(1'b1, 5'(i + 10), 1'b1, 1'b0, {32'hA5A5_0000, 32'(i)}, 1'b0, 1'b0);
      check_val("stall_ready", issue_ready, rdy_exp[i]);
      tick();
    end
    apply(1'b0, 5'd0, 1'b0, 1'b0, 64'd0, 1'b0, 1'b0);
    check_val("stall_held", m_q.size(), 64'd3);
    tick();
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, 5'd0, 1'b0, 1'b0, 64'd0, 1'b0, 1'b1);
      check_val("drain_rd", wb_rd, 5'(i + 10));
      tick();
    end
    apply(1'b0, 5'd0, 1'b0, 1'b0, 64'd0, 1'b0, 1'b1);
    check_val("drain_ready", issue_ready, 64'd1);
    check_val("drain_empty", wb_valid, 64'd0);
    tick();

    // rd=0 and wen=0 retire silently.
    apply(1'b1, 5'd0, 1'b1, 1'b0, 64'd0, 1'b0, 1'b1); tick();
    apply(1'b1, 5'd3, 1'b0, 1'b0, 64'h55, 1'b0, 1'b1);
    check_val("rd0_fwd", fwd_valid, 64'd0);
    tick();
    apply(1'b0, 5'd0, 1'b0, 1'b0, 64'h66, 1'b0, 1'b1);
    check_val("wen0_fwd", fwd_valid, 64'd0);
    check_val("rd0_wb", wb_valid, 64'd0);
    tick();
    apply(1'b0, 5'd0, 1'b0, 1'b0, 64'd0, 1'b0, 1'b1);
    check_val("wen0_wb", wb_valid, 64'd0);
    tick();

    // Flush with two buffered entries plus one in E1.
    apply(1'b1, 5'd1, 1'b1, 1'b0, 64'd0, 1'b0, 1'b0); tick();
    apply(1'b1, 5'd2, 1'b1, 1'b0, 64'h11, 1'b0, 1'b0); tick();
    apply(1'b1, 5'd3, 1'b1, 1'b0, 64'h22, 1'b0, 1'b0); tick();
    apply(1'b1, 5'd4, 1'b1, 1'b0, 64'h33, 1'b1, 1'b0);
    check_val("pre_flush_ready", issue_ready, 64'd0);
    tick();
    apply(1'b0, 5'd0, 1'b0, 1'b0, 64'h44, 1'b0, 1'b1);
    check_val("post_flush_valid", wb_valid, 64'd0);
    check_val("post_flush_ready", issue_ready, 64'd1);
    tick();
    idle(1'b1);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      sel = $urandom_range(0, 3);
      case (sel)
        1:       alu = {32'h0, 1'b1, 31'($urandom)};
        2:       alu = {32'hFFFF_FFFF, 1'b0, 31'($urandom)};
        default: alu = {$urandom, $urandom};
      endcase
      apply($urandom_range(0, 9) < 7, 5'($urandom), $urandom_range(0, 9) != 0,
            1'($urandom), alu, $urandom_range(0, 31) == 0, $urandom_range(0, 3) != 0);
      tick();
    end

    // Reset asserted mid-operation discards everything immediately.
    apply(1'b1, 5'd20, 1'b1, 1'b0, 64'd0, 1'b0, 1'b0); tick();
    apply(1'b1, 5'd21, 1'b1, 1'b0, 64'h77, 1'b0, 1'b0); tick();
    apply(1'b0, 5'd0, 1'b0, 1'b0, 64'h88, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    check_val("midrst_wb_valid", wb_valid, 64'd0);
    check_val("midrst_wb_data", wb_data, 64'd0);
    check_val("midrst_ready", issue_ready, 64'd1);
    check_val("midrst_fwd", fwd_valid, 64'd0);
    m_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) idle(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
